// File: rtl/cfg_reg_bank_if.sv
// Bus bundle for cfg_reg_bank: write/read request ports, error/update status and the exported registers.
// The master modport drives requests; the slave modport belongs to the register bank.
interface cfg_reg_bank_if #(
    parameter int WIDTH_REG = 8,
    parameter int ADDR      = 5,
    parameter int NUM_EXP   = 4
);
    logic                         i_wr_en;
    logic [ADDR-1:0]              i_wr_addr;
    logic [WIDTH_REG-1:0]         i_wr_data;
    logic [WIDTH_REG-1:0]         i_wr_mask;
    logic                         i_rd_en;
    logic [ADDR-1:0]              i_rd_addr;
    logic                         i_err_clr;
    logic [WIDTH_REG-1:0]         o_rd_data;
    logic                         o_rd_valid;
    logic                         o_err;
    logic [3:0]                   o_err_cnt;
    logic                         o_upd;
    logic [ADDR-1:0]              o_upd_addr;
    logic [NUM_EXP*WIDTH_REG-1:0] o_exp_regs;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_wr_mask, i_rd_en, i_rd_addr, i_err_clr,
        input  o_rd_data, o_rd_valid, o_err, o_err_cnt, o_upd, o_upd_addr, o_exp_regs
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_wr_mask, i_rd_en, i_rd_addr, i_err_clr,
        output o_rd_data, o_rd_valid, o_err, o_err_cnt, o_upd, o_upd_addr, o_exp_regs
    );
endinterface

// File: rtl/cfg_reg_bank.sv
// Configuration register bank: masked writes, 1-cycle reads, read-only protection,
// saturating illegal-access counter and change notification for the exported low registers.
module cfg_reg_bank #(
    parameter int WIDTH_REG = 8,
    parameter int DEPTH_REG = 16,
    parameter int ADDR      = 5,
    parameter int NUM_EXP   = 4,
    parameter logic [DEPTH_REG-1:0]           RO_MASK = '0,
    parameter logic [DEPTH_REG*WIDTH_REG-1:0] RST_VAL =
        (DEPTH_REG*WIDTH_REG)'({WIDTH_REG'(32), WIDTH_REG'(8'h81), WIDTH_REG'(10), WIDTH_REG'(5)})
) (
    input  logic           i_Ref_clk,
    input  logic           i_rst,
    cfg_reg_bank_if.slave  bus
);
    localparam logic [ADDR:0] LP_DEPTH = (ADDR+1)'(DEPTH_REG);
    localparam logic [ADDR:0] LP_NEXP  = (ADDR+1)'(NUM_EXP);

    logic [WIDTH_REG-1:0] r_regs [DEPTH_REG];
    logic [WIDTH_REG-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_err;
    logic [3:0]           r_err_cnt;
    logic                 r_upd;
    logic [ADDR-1:0]      r_upd_addr;

    logic [WIDTH_REG-1:0] w_rd_word;
    logic [WIDTH_REG-1:0] w_wr_old;
    logic [WIDTH_REG-1:0] w_wr_new;
    logic                 w_wr_ro;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_legal;
    logic                 w_wr_ill;
    logic                 w_rd_ill;
    logic                 w_upd;
    logic [1:0]           w_err_inc;

    function automatic logic [3:0] sat_cnt(input logic [3:0] cnt, input logic [1:0] inc);
        logic [4:0] sum;
        sum = {1'b0, cnt} + {3'b000, inc};
        return (sum > 5'd15) ? 4'hF : sum[3:0];
    endfunction

    // Address decode; out-of-range reads fall through to zero
    always_comb begin
        w_rd_word = '0;
        w_wr_old  = '0;
        w_wr_ro   = 1'b0;
        for (int k = 0; k < DEPTH_REG; k++) begin
            if (bus.i_rd_addr == ADDR'(k)) w_rd_word = r_regs[k];
            if (bus.i_wr_addr == ADDR'(k)) begin
                w_wr_old = r_regs[k];
                w_wr_ro  = RO_MASK[k];
            end
        end
    end

    assign w_wr_in_range = {1'b0, bus.i_wr_addr} < LP_DEPTH;
    assign w_rd_in_range = {1'b0, bus.i_rd_addr} < LP_DEPTH;
    assign w_wr_legal    = bus.i_wr_en && w_wr_in_range && !w_wr_ro;
    assign w_wr_ill      = bus.i_wr_en && !w_wr_legal;
    assign w_rd_ill      = bus.i_rd_en && !w_rd_in_range;
    assign w_wr_new      = (w_wr_old & ~bus.i_wr_mask) | (bus.i_wr_data & bus.i_wr_mask);
    assign w_upd         = w_wr_legal && ({1'b0, bus.i_wr_addr} < LP_NEXP) && (w_wr_new != w_wr_old);
    assign w_err_inc     = {1'b0, w_wr_ill} + {1'b0, w_rd_ill};

    always_ff @(posedge i_Ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < DEPTH_REG; k++) r_regs[k] <= RST_VAL[k*WIDTH_REG +: WIDTH_REG];
        end else if (w_wr_legal) begin
            for (int k = 0; k < DEPTH_REG; k++)
                if (bus.i_wr_addr == ADDR'(k)) r_regs[k] <= w_wr_new;
        end
    end

    // Status and read-return stage: everything below lands one cycle after the request
    always_ff @(posedge i_Ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= 4'h0;
            r_upd      <= 1'b0;
            r_upd_addr <= '0;
        end else begin
            r_rd_valid <= bus.i_rd_en;
            if (bus.i_rd_en) r_rd_data <= w_rd_word;
            r_err      <= w_wr_ill || w_rd_ill;
            r_err_cnt  <= bus.i_err_clr ? 4'h0 : sat_cnt(r_err_cnt, w_err_inc);
            r_upd      <= w_upd;
            if (w_upd) r_upd_addr <= bus.i_wr_addr;
        end
    end

    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_err      = r_err;
    assign bus.o_err_cnt  = r_err_cnt;
    assign bus.o_upd      = r_upd;
    assign bus.o_upd_addr = r_upd_addr;

    for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
        assign bus.o_exp_regs[g*WIDTH_REG +: WIDTH_REG] = r_regs[g];
    end
endmodule

// File: doc/cfg_reg_bank.md
CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH_REG, default 8, data width of each register in bits.
REQ-002 SHALL have parameter DEPTH_REG, default 16, number of registers.
REQ-003 SHALL have parameter ADDR, default 5, address width; ADDR SHALL satisfy 2^ADDR >= DEPTH_REG, so out-of-range addresses are encodable.
REQ-004 SHALL have parameter NUM_EXP, default 4, number of low-index registers exported combinationally, 1 <= NUM_EXP <= DEPTH_REG.
REQ-005 SHALL have parameter RO_MASK, default all zeros, DEPTH_REG bits; bit k = 1 makes register k read-only from the bus.
REQ-006 SHALL have parameter RST_VAL, DEPTH_REG*WIDTH_REG bits, register k reset value at slice k; default reg0=5, reg1=10, reg2=0x81, reg3=32, others 0.
REQ-007 SHALL have port i_Ref_clk, input, 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port i_rst, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port i_wr_en, input, 1, write request, sampled each cycle.
REQ-010 SHALL have port i_wr_addr, input, ADDR, write address.
REQ-011 SHALL have port i_wr_data, input, WIDTH_REG, write data.
REQ-012 SHALL have port i_wr_mask, input, WIDTH_REG, per-bit write enable (1 = update bit).
REQ-013 SHALL have port i_rd_en, input, 1, read request.
REQ-014 SHALL have port i_rd_addr, input, ADDR, read address.
REQ-015 SHALL have port i_err_clr, input, 1, clears the error counter.
REQ-016 SHALL have port o_rd_data, output, WIDTH_REG, registered read data.
REQ-017 SHALL have port o_rd_valid, output, 1, one-cycle pulse qualifying o_rd_data.
REQ-018 SHALL have port o_err, output, 1, one-cycle pulse on any illegal access.
REQ-019 SHALL have port o_err_cnt, output, 4, saturating illegal-access count.
REQ-020 SHALL have port o_upd, output, 1, one-cycle pulse when an exported register value changes.
REQ-021 SHALL have port o_upd_addr, output, ADDR, index of the changed exported register, valid with o_upd.
REQ-022 SHALL have port o_exp_regs, output, NUM_EXP*WIDTH_REG, registers 0..NUM_EXP-1 concatenated with reg0 at the LSBs.

Function
REQ-023 Independent ports: read and write SHALL both be serviced in the same cycle, with no mutual exclusion.
REQ-024 Legal write (addr < DEPTH_REG, RO_MASK bit 0): next reg = (reg & ~i_wr_mask) | (i_wr_data & i_wr_mask).
REQ-025 Read latency SHALL be 1 cycle; o_rd_valid SHALL pulse in the cycle after i_rd_en and is low otherwise.
REQ-026 o_rd_data SHALL hold its last value when o_rd_valid is low.
REQ-027 Same-address read and write in one cycle: the read SHALL return the pre-write (old) value.
REQ-028 Write to a read-only register or to addr >= DEPTH_REG: storage SHALL be unchanged and o_err SHALL pulse next cycle.
REQ-029 Read at addr >= DEPTH_REG: o_rd_valid SHALL pulse with o_rd_data = 0, and o_err SHALL pulse.
REQ-030 Illegal read and illegal write in the same cycle SHALL produce a single o_err pulse and increment o_err_cnt by 2, saturating at 15.
REQ-031 Any other illegal access SHALL increment o_err_cnt by 1, saturating at 15; it never wraps.
REQ-032 i_err_clr SHALL zero o_err_cnt next cycle; errors occurring in the same cycle are discarded.
REQ-033 o_upd SHALL pulse one cycle after a legal write to an index < NUM_EXP only if the stored value actually changes.
REQ-034 Writes with an all-zero i_wr_mask or identical data SHALL produce no o_upd pulse.
REQ-035 o_exp_regs SHALL reflect updated storage in the cycle after the write edge, with no extra latency.

Reset
REQ-036 On i_rst low, asynchronously: each reg k = RST_VAL slice k; o_rd_data=0, o_rd_valid=0, o_err=0, o_err_cnt=0, o_upd=0, o_upd_addr=0.
REQ-037 Reset asserted mid-access SHALL abort that access; no valid, error or update pulse SHALL follow deassertion.
REQ-038 Read-only registers SHALL hold their RST_VAL permanently.

Verification
REQ-039 Reset, then read addresses 0..3 -> o_rd_data 5, 10, 0x81, 32, each with o_rd_valid one cycle after its request.
REQ-040 Write 0xAA with mask 0x0F to reg1 (holding 10=0x0A) -> stored 0x0A, no o_upd; then mask 0xF0 -> 0xAA, o_upd=1, o_upd_addr=1.
REQ-041 Same cycle: write 0x55 to reg5 and read reg5 (holding 0) -> o_rd_data=0; a read of reg5 next cycle -> 0x55.
REQ-042 RO_MASK bit 2 set: write reg2 -> value stays 0x81, o_err pulses, o_err_cnt=1; 20 illegal reads at addr 20 -> o_err_cnt=15.
REQ-043 Assert i_err_clr -> o_err_cnt=0; pulse i_rst low between clock edges mid-write -> immediate RST_VAL contents and all outputs at reset values.
